// File: rtl/regfile_wb_if.sv
// Producer-side handshakes, register-file write port and scoreboard/forwarding taps of the writeback queue.
// master = producers/regfile side, slave = regfile_wb_queue.
interface regfile_wb_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned NR = 2 ** AW;

  logic          src0_valid;
  logic [AW-1:0] src0_addr;
  logic [DW-1:0] src0_data;
  logic          src0_ready;
  logic          src1_valid;
  logic [AW-1:0] src1_addr;
  logic [DW-1:0] src1_data;
  logic          src1_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] busy;
  logic [CW-1:0] count;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  modport master (
    output src0_valid, src0_addr, src0_data, src1_valid, src1_addr, src1_data, fwd_addr,
    input  src0_ready, src1_ready, wr_en, wr_addr, wr_data, busy, count, fwd_hit, fwd_data
  );

  modport slave (
    input  src0_valid, src0_addr, src0_data, src1_valid, src1_addr, src1_data, fwd_addr,
    output src0_ready, src1_ready, wr_en, wr_addr, wr_data, busy, count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback queue: two result producers feed an in-order FIFO drained at one register-file write per cycle.
// Define WB_FWD_EN to add the newest-first forwarding search over buffered results.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NR = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          src0_ready_c;
  logic          src1_ready_c;
  logic          push0;
  logic          push1;
  logic          pop;
  logic [NR-1:0] busy_c;
  logic          fwd_hit_c;
  logic [DW-1:0] fwd_data_c;

  // Free space comes from the registered count only; a same-cycle pop is not credited.
  assign src0_ready_c = count < CW'(DEPTH);
  assign src1_ready_c = bus.src0_valid ? (count <= CW'(DEPTH - 2)) : (count < CW'(DEPTH));

  // x0 handshakes complete but never occupy a slot.
  assign push0 = bus.src0_valid && src0_ready_c && (bus.src0_addr != '0);
  assign push1 = bus.src1_valid && src1_ready_c && (bus.src1_addr != '0);
  assign pop   = count != '0;

  assign bus.src0_ready = src0_ready_c;
  assign bus.src1_ready = src1_ready_c;
  assign bus.count      = count;
  assign bus.busy       = busy_c;
  assign bus.fwd_hit    = fwd_hit_c;
  assign bus.fwd_data   = fwd_data_c;

  // Storage; src0 takes the older slot when both push.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= wb_entry_t'{addr: bus.src0_addr, data: bus.src0_data};
    if (push1) mem[wr_ptr + PW'(push0)] <= wb_entry_t'{addr: bus.src1_addr, data: bus.src1_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(push0) + PW'(push1);
      count     <= count + CW'(push0) + CW'(push1) - CW'(pop);
      bus.wr_en <= pop;
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        bus.wr_addr <= mem[rd_ptr].addr;
        bus.wr_data <= mem[rd_ptr].data;
      end
    end
  end

  // Busy covers only entries still in the FIFO, not the one on the write port.
  always_comb begin
    busy_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) busy_c[mem[rd_ptr + PW'(k)].addr] = 1'b1;
    end
    busy_c[0] = 1'b0;
  end

`ifdef WB_FWD_EN
  // Oldest first so later (newer) matches override; the write-port entry is the oldest.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    if (bus.fwd_addr != '0) begin
      if (bus.wr_en && (bus.wr_addr == bus.fwd_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = bus.wr_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count) && (mem[rd_ptr + PW'(k)].addr == bus.fwd_addr)) begin
          fwd_hit_c  = 1'b1;
          fwd_data_c = mem[rd_ptr + PW'(k)].data;
        end
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^bus.fwd_addr;
  assign fwd_hit_c       = 1'b0;
  assign fwd_data_c      = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: a queue model of buffered results checked every cycle,
// plus directed scenarios; a second DEPTH=2 instance exercises the full condition.
`timescale 1ns/1ps
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  ent_t        fifo_q[$];
  ent_t        wr_log[$];
  logic        exp_wr_en = 1'b0;
  logic [4:0]  exp_wr_addr = '0;
  logic [31:0] exp_wr_data = '0;
  logic [31:0] tb_regs [32];

  always #5 clk = ~clk;

  regfile_wb_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();
  regfile_wb_if #(.DEPTH(2), .AW(5), .DW(32)) bus2 ();

  regfile_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  regfile_wb_queue #(.DEPTH(2), .AW(5), .DW(32)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Per-cycle scoreboard: fifo_q holds accepted results until they are due on the write port.
  always @(negedge clk) begin
    if (mon_en) begin
      int          free_n;
      logic        exp_r0, exp_r1, exp_hit;
      logic [31:0] exp_busy, exp_fd;
      ent_t        e;
      free_n = DEPTH - fifo_q.size();
      exp_r0 = free_n >= 1;
      exp_r1 = free_n >= (bus.src0_valid ? 2 : 1);
      exp_busy = '0;
      foreach (fifo_q[i]) exp_busy[fifo_q[i].addr] = 1'b1;
      exp_busy[0] = 1'b0;
      exp_hit = 1'b0;
      exp_fd  = '0;
`ifdef WB_FWD_EN
      if (bus.fwd_addr != 5'd0) begin
        if (exp_wr_en && exp_wr_addr == bus.fwd_addr) begin exp_hit = 1'b1; exp_fd = exp_wr_data; end
        foreach (fifo_q[i]) if (fifo_q[i].addr == bus.fwd_addr) begin exp_hit = 1'b1; exp_fd = fifo_q[i].data; end
      end
`endif
      checks++; if (bus.count !== 3'(fifo_q.size())) begin errors++; $display("FAIL mon_count: got %0d want %0d", bus.count, fifo_q.size()); end
      checks++; if (bus.wr_en !== exp_wr_en) begin errors++; $display("FAIL mon_wr_en: got %b want %b", bus.wr_en, exp_wr_en); end
      if (exp_wr_en) begin
        checks++; if (bus.wr_addr !== exp_wr_addr || bus.wr_data !== exp_wr_data) begin
          errors++; $display("FAIL mon_wr: got r%0d=%h want r%0d=%h", bus.wr_addr, bus.wr_data, exp_wr_addr, exp_wr_data);
        end
      end
      checks++; if (bus.src0_ready !== exp_r0 || bus.src1_ready !== exp_r1) begin
        errors++; $display("FAIL mon_ready: got %b%b want %b%b", bus.src0_ready, bus.src1_ready, exp_r0, exp_r1);
      end
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL mon_busy: got %h want %h", bus.busy, exp_busy); end
      checks++; if (bus.fwd_hit !== exp_hit || bus.fwd_data !== exp_fd) begin
        errors++; $display("FAIL mon_fwd: got %b/%h want %b/%h", bus.fwd_hit, bus.fwd_data, exp_hit, exp_fd);
      end
      if (bus.wr_en === 1'b1) begin
        tb_regs[bus.wr_addr] = bus.wr_data;
        wr_log.push_back(ent_t'{addr: bus.wr_addr, data: bus.wr_data});
      end
      if (rst) begin
        fifo_q.delete();
        exp_wr_en = 1'b0;
      end else begin
        if (fifo_q.size() > 0) begin
          e = fifo_q.pop_front();
          exp_wr_en = 1'b1; exp_wr_addr = e.addr; exp_wr_data = e.data;
        end else exp_wr_en = 1'b0;
        if (bus.src0_valid && exp_r0 && bus.src0_addr != 5'd0) fifo_q.push_back(ent_t'{addr: bus.src0_addr, data: bus.src0_data});
        if (bus.src1_valid && exp_r1 && bus.src1_addr != 5'd0) fifo_q.push_back(ent_t'{addr: bus.src1_addr, data: bus.src1_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.src0_valid = 1'b0; bus.src0_addr = '0; bus.src0_data = '0;
    bus.src1_valid = 1'b0; bus.src1_addr = '0; bus.src1_data = '0;
    bus2.src0_valid = 1'b0; bus2.src0_addr = '0; bus2.src0_data = '0;
    bus2.src1_valid = 1'b0; bus2.src1_addr = '0; bus2.src1_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); bus.fwd_addr = 5'd7; bus2.fwd_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0) begin
      errors++; $display("FAIL reset_wr: got %b r%0d %h want 0 r0 0", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.count !== 3'd0 || bus.busy !== 32'd0) begin errors++; $display("FAIL reset_state: count %0d busy %h want 0 0", bus.count, bus.busy); end
    checks++; if (bus.src0_ready !== 1'b1 || bus.src1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b%b want 11", bus.src0_ready, bus.src1_ready); end
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd: got %b %h want 0 0", bus.fwd_hit, bus.fwd_data); end
    checks++; if (bus2.count !== 2'd0 || bus2.wr_en !== 1'b0) begin errors++; $display("FAIL reset_dut2: count %0d wr_en %b want 0 0", bus2.count, bus2.wr_en); end
  endtask

  task automatic test_single();
    tick(); bus.src0_valid = 1'b1; bus.src0_addr = 5'd5; bus.src0_data = 32'hA5A5_A5A5;
    @(negedge clk);
    checks++; if (bus.src0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.src0_ready); end
    tick(); idle();
    @(negedge clk);
    checks++; if (bus.count !== 3'd1 || bus.wr_en !== 1'b0 || bus.busy[5] !== 1'b1) begin
      errors++; $display("FAIL single_buffered: count %0d wr_en %b busy5 %b want 1 0 1", bus.count, bus.wr_en, bus.busy[5]); end
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL single_write: got %b r%0d %h want 1 r5 a5a5a5a5", bus.wr_en, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.count !== 3'd0 || bus.busy[5] !== 1'b0) begin errors++; $display("FAIL single_retire: count %0d busy5 %b want 0 0", bus.count, bus.busy[5]); end
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL single_idle: wr_en %b want 0", bus.wr_en); end
  endtask

  task automatic test_dual();
    tick();
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd1; bus.src0_data = 32'd1;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd2; bus.src1_data = 32'd2;
    @(negedge clk);
    checks++; if (bus.src0_ready !== 1'b1 || bus.src1_ready !== 1'b1) begin errors++; $display("FAIL dual_ready: got %b%b want 11", bus.src0_ready, bus.src1_ready); end
    tick(); idle(); @(negedge clk);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL dual_count: got %0d want 2", bus.count); end
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd1 || bus.wr_data !== 32'd1) begin
      errors++; $display("FAIL dual_first: got %b r%0d %h want 1 r1 1", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd2 || bus.wr_data !== 32'd2) begin
      errors++; $display("FAIL dual_second: got %b r%0d %h want 1 r2 2", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick(); @(negedge clk);
  endtask

  // Pops are not credited, so with two producers and DEPTH=4 occupancy peaks at 3.
  task automatic test_backpressure();
    int n0 = 0, n1 = 0, maxc = 0;
    bit stall_seen = 1'b0, a0, a1, done = 1'b0;
    logic [4:0] order [8] = '{5'd8, 5'd12, 5'd9, 5'd13, 5'd10, 5'd11, 5'd14, 5'd15};
    logic [31:0] want_d;
    wr_log.delete();
    tick();
    for (int cyc = 0; cyc < 30 && (n0 < 4 || n1 < 4); cyc++) begin
      bus.src0_valid = (n0 < 4); bus.src0_addr = 5'(8 + n0);  bus.src0_data = 32'(32'h100 + n0);
      bus.src1_valid = (n1 < 4); bus.src1_addr = 5'(12 + n1); bus.src1_data = 32'(32'h200 + n1);
      @(negedge clk);
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      if (bus.src1_valid && !bus.src1_ready && bus.src0_ready) stall_seen = 1'b1;
      a0 = bus.src0_valid && bus.src0_ready;
      a1 = bus.src1_valid && bus.src1_ready;
      tick();
      if (a0) n0++;
      if (a1) n1++;
    end
    idle();
    checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL bp_accept: got %0d/%0d want 4/4 within budget", n0, n1); end
    checks++; if (maxc != 3) begin errors++; $display("FAIL bp_peak: got %0d want 3", maxc); end
    checks++; if (!stall_seen) begin errors++; $display("FAIL bp_src1_stall: got 0 want 1"); end
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.count == 3'd0 && bus.wr_en == 1'b0) begin done = 1'b1; break; end
    end
    checks++; if (!done) begin errors++; $display("FAIL bp_drain: count %0d wr_en %b want drained", bus.count, bus.wr_en); end
    checks++; if (wr_log.size() != 8) begin errors++; $display("FAIL bp_nwrites: got %0d want 8", wr_log.size()); end
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      want_d = (order[i] < 5'd12) ? 32'(32'h100 + int'(order[i]) - 8) : 32'(32'h200 + int'(order[i]) - 12);
      checks++; if (wr_log[i].addr !== order[i] || wr_log[i].data !== want_d) begin
        errors++; $display("FAIL bp_order%0d: got r%0d=%h want r%0d=%h", i, wr_log[i].addr, wr_log[i].data, order[i], want_d); end
    end
  endtask

  task automatic test_x0();
    tick(); bus.src1_valid = 1'b1; bus.src1_addr = 5'd0; bus.src1_data = 32'hFFFF;
    @(negedge clk);
    checks++; if (bus.src1_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", bus.src1_ready); end
    tick(); idle(); @(negedge clk);
    checks++; if (bus.count !== 3'd0 || bus.wr_en !== 1'b0 || bus.busy[0] !== 1'b0) begin
      errors++; $display("FAIL x0_drop: count %0d wr_en %b busy0 %b want 0 0 0", bus.count, bus.wr_en, bus.busy[0]); end
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL x0_nowrite: wr_en %b want 0", bus.wr_en); end
    tick();
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd0; bus.src0_data = 32'hDEAD;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd9; bus.src1_data = 32'h99;
    tick(); idle(); @(negedge clk);
    checks++; if (bus.count !== 3'd1 || bus.busy[9] !== 1'b1 || bus.busy[0] !== 1'b0) begin
      errors++; $display("FAIL x0_mixed: count %0d busy9 %b busy0 %b want 1 1 0", bus.count, bus.busy[9], bus.busy[0]); end
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'h99) begin
      errors++; $display("FAIL x0_mixed_write: got %b r%0d %h want 1 r9 99", bus.wr_en, bus.wr_addr, bus.wr_data); end
    tick(); @(negedge clk);
  endtask

  task automatic test_same_addr();
    bus.fwd_addr = 5'd7;
    tick(); bus.src0_valid = 1'b1; bus.src0_addr = 5'd7; bus.src0_data = 32'h11;
    tick(); idle(); bus.src1_valid = 1'b1; bus.src1_addr = 5'd7; bus.src1_data = 32'h22;
    @(negedge clk);
    checks++; if (bus.count !== 3'd1 || bus.busy[7] !== 1'b1) begin errors++; $display("FAIL waw_first: count %0d busy7 %b want 1 1", bus.count, bus.busy[7]); end
    tick(); idle(); @(negedge clk);
    checks++; if (bus.wr_data !== 32'h11 || bus.busy[7] !== 1'b1) begin errors++; $display("FAIL waw_mid: data %h busy7 %b want 11 1", bus.wr_data, bus.busy[7]); end
`ifdef WB_FWD_EN
    checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h22) begin errors++; $display("FAIL waw_fwd: got %b %h want 1 22", bus.fwd_hit, bus.fwd_data); end
`else
    checks++; if (bus.fwd_hit !== 1'b0 || bus.fwd_data !== 32'h0) begin errors++; $display("FAIL waw_fwd: got %b %h want 0 0", bus.fwd_hit, bus.fwd_data); end
`endif
    tick(); @(negedge clk);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h22 || bus.busy[7] !== 1'b0) begin
      errors++; $display("FAIL waw_last: wr_en %b data %h busy7 %b want 1 22 0", bus.wr_en, bus.wr_data, bus.busy[7]); end
    tick(); @(negedge clk);
    checks++; if (tb_regs[7] !== 32'h22) begin errors++; $display("FAIL waw_final: r7 %h want 22", tb_regs[7]); end
    checks++; if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL waw_fwd_clear: got %b want 0", bus.fwd_hit); end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd20; bus.src0_data = 32'h20;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd21; bus.src1_data = 32'h21;
    tick();
    bus.src0_addr = 5'd22; bus.src0_data = 32'h22; bus.src1_addr = 5'd23; bus.src1_data = 32'h23;
    tick(); idle(); rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rstmid_fill: count %0d want 3", bus.count); end
    tick(); rst = 1'b0; @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0 || bus.count !== 3'd0 || bus.busy !== 32'd0) begin
      errors++; $display("FAIL rstmid_clear: wr_en %b count %0d busy %h want 0 0 0", bus.wr_en, bus.count, bus.busy); end
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: wr_en %b want 0", i, bus.wr_en); end
    end
  endtask

  // DEPTH=2: two same-cycle pushes fill the queue and both readies drop.
  task automatic test_full_depth2();
    tick();
    bus2.src0_valid = 1'b1; bus2.src0_addr = 5'd3; bus2.src0_data = 32'h33;
    bus2.src1_valid = 1'b1; bus2.src1_addr = 5'd4; bus2.src1_data = 32'h44;
    tick();
    bus2.src0_addr = 5'd5; bus2.src0_data = 32'h55; bus2.src1_addr = 5'd6; bus2.src1_data = 32'h66;
    @(negedge clk);
    checks++; if (bus2.count !== 2'd2 || bus2.src0_ready !== 1'b0 || bus2.src1_ready !== 1'b0) begin
      errors++; $display("FAIL full_readies: count %0d ready %b%b want 2 00", bus2.count, bus2.src0_ready, bus2.src1_ready); end
    tick(); @(negedge clk);
    checks++; if (bus2.wr_addr !== 5'd3 || bus2.src0_ready !== 1'b1 || bus2.src1_ready !== 1'b0) begin
      errors++; $display("FAIL full_one_free: wr r%0d ready %b%b want r3 10", bus2.wr_addr, bus2.src0_ready, bus2.src1_ready); end
    tick(); bus2.src0_valid = 1'b0; @(negedge clk);
    checks++; if (bus2.wr_addr !== 5'd4 || bus2.src1_ready !== 1'b1) begin
      errors++; $display("FAIL full_src1: wr r%0d ready1 %b want r4 1", bus2.wr_addr, bus2.src1_ready); end
    tick(); idle(); @(negedge clk);
    checks++; if (bus2.wr_en !== 1'b1 || bus2.wr_addr !== 5'd5 || bus2.wr_data !== 32'h55) begin
      errors++; $display("FAIL full_w5: got %b r%0d %h want 1 r5 55", bus2.wr_en, bus2.wr_addr, bus2.wr_data); end
    tick(); @(negedge clk);
    checks++; if (bus2.wr_en !== 1'b1 || bus2.wr_addr !== 5'd6 || bus2.wr_data !== 32'h66 || bus2.count !== 2'd0) begin
      errors++; $display("FAIL full_w6: got %b r%0d %h count %0d want 1 r6 66 0", bus2.wr_en, bus2.wr_addr, bus2.wr_data, bus2.count); end
    tick(); @(negedge clk);
    checks++; if (bus2.wr_en !== 1'b0) begin errors++; $display("FAIL full_idle: wr_en %b want 0", bus2.wr_en); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_backpressure();
    test_x0();
    test_same_addr();
    test_reset_mid();
    test_full_depth2();
    tick();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
